// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side sequencing controller: per-register write scoreboard for RAW stalls,
// plus fetch freeze while a PC-writing instruction resolves and refill on redirect.
module pipeline_hazard_ctrl #(
  parameter int selectionBits = 4,
  parameter int branchLatency = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  input  logic [selectionBits-1:0]      dec_rs1,
  input  logic [selectionBits-1:0]      dec_rs2,
  input  logic                          dec_uses_rs1,
  input  logic                          dec_uses_rs2,
  input  logic                          dec_wr_en,
  input  logic [selectionBits-1:0]      dec_rd,
  input  logic                          dec_pc_wr,
  input  logic                          wb_wr_en,
  input  logic [selectionBits-1:0]      wb_rd,
  input  logic                          redirect,
  output logic                          stall_f,
  output logic                          bubble_ex,
  output logic                          flush_fd,
  output logic                          fetch_active,
  output logic [(1<<selectionBits)-1:0] busy_mask,
  output logic [1:0]                    ctrl_state,
  output logic                          err
);
  localparam int NumRegs = 1 << selectionBits;
  localparam int WaitW   = (branchLatency < 2) ? 1 : $clog2(branchLatency + 1);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    BRANCH_WAIT = 2'd1,
    REFILL      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               err_q, err_d;
  logic [1:0]         count_q [NumRegs];
  logic [1:0]         count_d [NumRegs];
  logic [NumRegs-1:0] busy_q, busy_d;

  logic hazard, issue, underflow, redirect_err;
  logic stall_c, bubble_c, flush_c, fetch_c;

  // No bypass: a register retiring this cycle is still seen as pending here.
  assign hazard = dec_valid & ((dec_uses_rs1 & (count_q[dec_rs1] != 2'd0)) |
                               (dec_uses_rs2 & (count_q[dec_rs2] != 2'd0)) |
                               (dec_wr_en    & (count_q[dec_rd]  == 2'd3)));
  assign issue     = dec_valid & ~hazard & (state_q == RUN);
  assign underflow = wb_wr_en & (count_q[wb_rd] == 2'd0);

  for (genvar gi = 0; gi < NumRegs; gi++) begin : g_sb
    logic inc, dec;
    assign inc = issue & dec_wr_en & (dec_rd == selectionBits'(gi));
    assign dec = wb_wr_en & (wb_rd == selectionBits'(gi));

    always_comb begin
      count_d[gi] = count_q[gi];
      if (inc && !dec)
        count_d[gi] = count_q[gi] + 2'd1;
      else if (dec && !inc && count_q[gi] != 2'd0)
        count_d[gi] = count_q[gi] - 2'd1;
      busy_d[gi] = (count_d[gi] != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q[gi] <= 2'd0;
        busy_q[gi]  <= 1'b0;
      end else begin
        count_q[gi] <= count_d[gi];
        busy_q[gi]  <= busy_d[gi];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    stall_c      = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    fetch_c      = 1'b1;
    redirect_err = 1'b0;
    case (state_q)
      RUN: begin
        stall_c      = hazard;
        bubble_c     = hazard;
        fetch_c      = ~hazard;
        redirect_err = redirect;
        if (issue && dec_pc_wr) begin
          wait_d  = WaitW'(branchLatency);
          state_d = BRANCH_WAIT;
        end
      end
      BRANCH_WAIT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        fetch_c  = 1'b0;
        // Redirect is only legal on the final wait cycle, when the branch is in memory.
        if (wait_q == WaitW'(1)) begin
          wait_d  = '0;
          state_d = redirect ? REFILL : RUN;
        end else begin
          wait_d       = wait_q - WaitW'(1);
          redirect_err = redirect;
        end
      end
      REFILL: begin
        flush_c      = 1'b1;
        bubble_c     = 1'b1;
        redirect_err = redirect;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
    err_d = err_q | redirect_err | underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign stall_f      = ~rst & stall_c;
  assign bubble_ex    = ~rst & bubble_c;
  assign flush_fd     = ~rst & flush_c;
  assign fetch_active = rst | fetch_c;
  assign busy_mask    = busy_q;
  assign ctrl_state   = state_q;
  assign err          = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: cycle-indexed behavioural model
// compared every cycle, plus literal expectations at the interesting cycles.
module tb_pipeline_hazard_ctrl;
  localparam int SB = 4;
  localparam int NR = 16;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid, dec_uses_rs1, dec_uses_rs2, dec_wr_en, dec_pc_wr;
  logic [SB-1:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic          wb_wr_en, redirect;
  logic          stall_f, bubble_ex, flush_fd, fetch_active, err;
  logic [NR-1:0] busy_mask;
  logic [1:0]    ctrl_state;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.selectionBits(SB), .branchLatency(BL)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_wr_en(dec_wr_en), .dec_rd(dec_rd), .dec_pc_wr(dec_pc_wr),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .redirect(redirect),
    .stall_f(stall_f), .bubble_ex(bubble_ex), .flush_fd(flush_fd),
    .fetch_active(fetch_active), .busy_mask(busy_mask),
    .ctrl_state(ctrl_state), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending-write counts per register and a cycle timeline for branches.
  int cnt [NR];
  int cyc, br_start, refill_cyc;
  bit m_err;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    cyc = 0; br_start = -1000; refill_cyc = -1000; m_err = 0;
  endtask

  function automatic int m_state();
    if (cyc == refill_cyc) return 2;
    if (cyc > br_start && cyc <= br_start + BL) return 1;
    return 0;
  endfunction

  function automatic bit m_hazard();
    return dec_valid && ((dec_uses_rs1 && cnt[dec_rs1] != 0) ||
                         (dec_uses_rs2 && cnt[dec_rs2] != 0) ||
                         (dec_wr_en && cnt[dec_rd] == 3));
  endfunction

  task automatic settle();
    int st;
    bit hz;
    logic [NR-1:0] b;
    @(negedge clk);
    if (!rst) begin
      st = m_state();
      hz = m_hazard();
      for (int i = 0; i < NR; i++) b[i] = (cnt[i] != 0);
      chk("ctrl_state", 32'(ctrl_state), 32'(st));
      chk("busy_mask", 32'(busy_mask), 32'(b));
      chk("err", 32'(err), 32'(m_err));
      chk("stall_f", 32'(stall_f), 32'((st == 1) || (st == 0 && hz)));
      chk("bubble_ex", 32'(bubble_ex), 32'((st != 0) || hz));
      chk("flush_fd", 32'(flush_fd), 32'(st == 2));
      chk("fetch_active", 32'(fetch_active), 32'((st == 2) || (st == 0 && !hz)));
    end
  endtask

  task automatic advance();
    int st;
    bit hz, iss, decide;
    @(posedge clk);
    if (!rst) begin
      st = m_state();
      hz = m_hazard();
      iss = dec_valid && !hz && st == 0;
      decide = (st == 1) && (cyc == br_start + BL);
      if (wb_wr_en && cnt[wb_rd] == 0) m_err = 1;
      if (redirect && !decide) m_err = 1;
      if (decide && redirect) refill_cyc = cyc + 1;
      if (iss && dec_wr_en) cnt[dec_rd]++;
      if (wb_wr_en && cnt[wb_rd] > 0) cnt[wb_rd]--;
      if (iss && dec_pc_wr) br_start = cyc;
      cyc++;
    end
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input bit wr, input int rd, input bit pc);
    dec_valid = v; dec_rs1 = 4'(rs1); dec_uses_rs1 = u1; dec_rs2 = 4'(rs2);
    dec_uses_rs2 = u2; dec_wr_en = wr; dec_rd = 4'(rd); dec_pc_wr = pc;
  endtask

  task automatic wbv(input bit en, input int rd);
    wb_wr_en = en; wb_rd = 4'(rd);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_mask), 32'd0);
    chk({tag, "_state"}, 32'(ctrl_state), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fa"}, 32'(fetch_active), 32'd1);
    chk({tag, "_stall"}, 32'(stall_f), 32'd0);
    chk({tag, "_bubble"}, 32'(bubble_ex), 32'd0);
    chk({tag, "_flush"}, 32'(flush_fd), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0); wbv(0, 0); redirect = 1'b0;
    model_reset();
    #1 chk_reset_outputs("init_rst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // RAW on r5: producer at t, reader stalls t+1..t+3, commit at t+3, issue at t+4
    drv(1, 0, 0, 0, 0, 1, 5, 0); step();
    drv(1, 5, 1, 0, 0, 0, 0, 0);
    settle(); chk("raw_t1_stall", 32'(stall_f), 32'd1); chk("raw_t1_busy5", 32'(busy_mask[5]), 32'd1); advance();
    settle(); chk("raw_t2_stall", 32'(stall_f), 32'd1); advance();
    wbv(1, 5);
    settle(); chk("raw_t3_stall", 32'(stall_f), 32'd1); chk("raw_t3_bubble", 32'(bubble_ex), 32'd1);
    chk("raw_t3_busy5", 32'(busy_mask[5]), 32'd1); advance();
    wbv(0, 0);
    settle(); chk("raw_t4_stall", 32'(stall_f), 32'd0); chk("raw_t4_busy5", 32'(busy_mask[5]), 32'd0);
    chk("raw_t4_fa", 32'(fetch_active), 32'd1); advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Same-cycle issue and retire on r2 keeps its count at 1
    drv(1, 0, 0, 0, 0, 1, 2, 0); step();
    wbv(1, 2);
    settle(); chk("sim_issue_stall", 32'(stall_f), 32'd0); advance();
    wbv(0, 0); drv(1, 7, 1, 0, 0, 0, 0, 0);
    settle(); chk("sim_busy2", 32'(busy_mask[2]), 32'd1); chk("sim_r7_stall", 32'(stall_f), 32'd0); advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0); wbv(1, 2); step();
    wbv(0, 0);
    settle(); chk("sim_busy2_clear", 32'(busy_mask[2]), 32'd0); advance();

    // Taken branch
    drv(1, 0, 0, 0, 0, 0, 0, 1);
    settle(); chk("tb_t0_state", 32'(ctrl_state), 32'd0); advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("tb_t1_state", 32'(ctrl_state), 32'd1); chk("tb_t1_fa", 32'(fetch_active), 32'd0);
    chk("tb_t1_flush", 32'(flush_fd), 32'd0); advance();
    redirect = 1'b1;
    settle(); chk("tb_t2_state", 32'(ctrl_state), 32'd1); chk("tb_t2_fa", 32'(fetch_active), 32'd0); advance();
    redirect = 1'b0;
    settle(); chk("tb_t3_state", 32'(ctrl_state), 32'd2); chk("tb_t3_flush", 32'(flush_fd), 32'd1);
    chk("tb_t3_fa", 32'(fetch_active), 32'd1); chk("tb_t3_stall", 32'(stall_f), 32'd0); advance();
    settle(); chk("tb_t4_state", 32'(ctrl_state), 32'd0); chk("tb_t4_flush", 32'(flush_fd), 32'd0);
    chk("tb_t4_err", 32'(err), 32'd0); advance();

    // Not-taken branch
    drv(1, 0, 0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();
    step();
    settle(); chk("nt_t3_state", 32'(ctrl_state), 32'd0); chk("nt_t3_flush", 32'(flush_fd), 32'd0); advance();

    // Async reset in BRANCH_WAIT with count[3]=2
    drv(1, 0, 0, 0, 0, 1, 3, 0); step(); step();
    drv(1, 0, 0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("rs_pre_state", 32'(ctrl_state), 32'd1); chk("rs_pre_busy3", 32'(busy_mask[3]), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rs_mid");
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    drv(1, 3, 1, 0, 0, 0, 0, 0);
    settle(); chk("rs_r3_stall", 32'(stall_f), 32'd0); advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Redirect in RUN sets sticky err
    redirect = 1'b1; step();
    redirect = 1'b0;
    settle(); chk("err_redirect", 32'(err), 32'd1); advance();
    step(); step();
    #2 rst = 1'b1;
    #1 chk("err_cleared", 32'(err), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;

    // Retire of r9 with nothing pending
    wbv(1, 9); step();
    wbv(0, 0);
    settle(); chk("err_underflow", 32'(err), 32'd1); chk("err_uf_busy", 32'(busy_mask), 32'd0); advance();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
